nibble_serial_sub: RTL and testbench

Multi-cycle unsigned subtractor that sequences one shared 4-bit adder-based subtract slice (a + ~b + carry-in) across a WIDTH-bit operand, one nibble per clock, least-significant nibble first, with borrow chained between nibbles. It sits between a requester issuing start/operand pulses and the 4-bit datapath, and trades latency for area in the assignment datapath family.

---
 rtl/nibble_serial_sub_pkg.sv | 13 +
 rtl/nibble_serial_sub_if.sv | 38 +++
 rtl/nibble_serial_sub_addsub.sv | 22 ++
 rtl/nibble_serial_sub.sv | 103 ++++++++++
 tb/tb_nibble_serial_sub.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_sub_pkg.sv
// Shared constants and state encoding for the nibble-serial subtractor.
// Imported by the slice, the interface users and the top.
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Request/result bundle between a requester and the serial subtractor.
// The requester drives start/a/b; the subtractor returns status and result.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow,
        input  zero
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow,
        output zero
    );

endinterface

// File: rtl/nibble_serial_sub_addsub.sv
// One 4-bit subtract slice: a_n + ~b_n + cin.
// cout = 1 means this nibble did not borrow.
module nibble_addsub
    import nibble_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_n,
    input  logic [NIBBLE_W-1:0] b_n,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] sum;

    assign sum = {1'b0, a_n}
               + {1'b0, ~b_n}
               + {{NIBBLE_W{1'b0}}, cin};

    assign s    = sum[NIBBLE_W-1:0];
    assign cout = sum[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle unsigned subtractor: one shared 4-bit slice walked over
// the operands LS nibble first, borrow chained through a carry flop.
module nibble_serial_sub
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    nibble_serial_sub_if.slave bus
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;

    logic [WIDTH-1:0] res_diff;
    logic             res_borrow;
    logic             res_zero;

    logic [NIBBLE_W-1:0] a_n;
    logic [NIBBLE_W-1:0] b_n;
    logic [NIBBLE_W-1:0] s;
    logic                cout;
    logic [WIDTH-1:0]    next_work;

    assign a_n = op_a[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign b_n = op_b[NIBBLE_W*int'(idx) +: NIBBLE_W];

    nibble_addsub u_slice (
        .a_n  (a_n),
        .b_n  (b_n),
        .cin  (carry),
        .s    (s),
        .cout (cout)
    );

    // Merge the nibble being produced this cycle so the final
    // cycle can publish the full result without an extra stage.
    always_comb begin
        next_work = work;
        next_work[NIBBLE_W*int'(idx) +: NIBBLE_W] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry      <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            work       <= '0;
            res_diff   <= '0;
            res_borrow <= 1'b0;
            res_zero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.b;
                        idx   <= '0;
                        carry <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work  <= next_work;
                    carry <= cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx        <= '0;
                        res_diff   <= next_work;
                        res_borrow <= ~cout;
                        res_zero   <= (next_work == '0);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.diff   = res_diff;
    assign bus.borrow = res_borrow;
    assign bus.zero   = res_zero;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub: vector table plus sequences
// for start-held back-to-back operation and mid-run reset.
module tb_nibble_serial_sub;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        borrow;
        logic        zero;
    } vec_t;

    vec_t vecs [8];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_diff;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [15:0] d,
                          input logic        bo,
                          input logic        z,
                          input string       tag);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        check({tag, " busy_e0"}, 32'(bus.busy), 32'd1);
        check({tag, " done_e0"}, 32'(bus.done), 32'd0);
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            check({tag, " diff_held"}, 32'(bus.diff), 32'(last_diff));
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(NIB));
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, " diff"}, 32'(bus.diff), 32'(d));
        check({tag, " borrow"}, 32'(bus.borrow), 32'(bo));
        check({tag, " zero"}, 32'(bus.zero), 32'(z));
        last_diff = d;
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, " diff_keep"}, 32'(bus.diff), 32'(d));
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;

        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8001, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h00F0, 16'h0E1F, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_diff = '0;
        #2;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst diff", 32'(bus.diff), 32'd0);
        check("rst borrow", 32'(bus.borrow), 32'd0);
        check("rst zero", 32'(bus.zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff,
                   vecs[i].borrow, vecs[i].zero,
                   $sformatf("vec%0d", i));
        end

        // start held high; operands change right after capture
        dones       = 0;
        first_done  = 0;
        second_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0010;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.a = 16'h0005;
        bus.b = 16'h0003;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (first_done == 0) first_done = e;
                else second_done = e;
            end
            if (e == 4) begin
                check("held diff1", 32'(bus.diff), 32'h000F);
                check("held borrow1", 32'(bus.borrow), 32'd0);
            end
            if (e == 5) check("held idle gap", 32'(bus.busy), 32'd0);
            if (e == 6) begin
                check("held restart", 32'(bus.busy), 32'd1);
                check("held diff kept", 32'(bus.diff), 32'h000F);
                bus.start = 1'b0;
            end
            if (e == 10) begin
                check("held diff2", 32'(bus.diff), 32'h0002);
                check("held borrow2", 32'(bus.borrow), 32'd0);
            end
        end
        check("held done count", 32'(dones), 32'd2);
        check("held done1 edge", 32'(first_done), 32'd4);
        check("held done2 edge", 32'(second_done), 32'd10);
        last_diff = 16'h0002;

        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, "pre_rst");

        // reset asserted after two nibbles of an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst done", 32'(bus.done), 32'd0);
        check("mid rst diff", 32'(bus.diff), 32'd0);
        check("mid rst borrow", 32'(bus.borrow), 32'd0);
        check("mid rst zero", 32'(bus.zero), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("in rst done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("post rst idle", 32'(bus.busy), 32'd0);
        end

        run_op(16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
